// File: rtl/reset_seq_pkg.sv
// Shared types and elaboration helpers for the reset release sequencer.
package reset_seq_pkg;

    typedef enum logic [2:0] {
        ASSERT   = 3'd0,
        WAIT_ACK = 3'd1,
        GAP      = 3'd2,
        DONE     = 3'd3,
        FAULT    = 3'd4
    } seq_state_t;

    // Parameters below 1 would make counters and stage vectors degenerate.
    function automatic int clamp_min1(input int value);
        return (value < 1) ? 1 : value;
    endfunction

    // Width of a stage index; a single-stage build still gets one bit.
    function automatic int stage_idx_width(input int num_stages);
        int n;
        n = clamp_min1(num_stages);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // The shared counter must hold the largest terminal value of any phase.
    function automatic int cnt_width(input int hold, input int gap, input int tmo);
        int m;
        int w;
        m = clamp_min1(hold);
        if (clamp_min1(gap) > m) m = clamp_min1(gap);
        if (clamp_min1(tmo) > m) m = clamp_min1(tmo);
        w = $clog2(m + 1);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/reset_release_sequencer.sv
// Releases downstream reset domains one at a time once the filtered reset
// request has been stable high, waiting for each domain's ack in turn and
// flagging a sticky fault when an ack never arrives.
module reset_release_sequencer
    import reset_seq_pkg::*;
#(
    parameter int NUM_STAGES  = 4,
    parameter int HOLD_CYCLES = 16,
    parameter int GAP_CYCLES  = 8,
    parameter int ACK_TIMEOUT = 255
) (
    input  logic                                    clk,
    input  logic                                    rst,
    input  logic                                    req_n,
    input  logic [clamp_min1(NUM_STAGES)-1:0]       stage_ack,
    output logic [clamp_min1(NUM_STAGES)-1:0]       rst_out_n,
    output logic                                    seq_done,
    output logic                                    fault,
    output logic [stage_idx_width(NUM_STAGES)-1:0]  fault_stage
);

    localparam int NS   = clamp_min1(NUM_STAGES);
    localparam int HOLD = clamp_min1(HOLD_CYCLES);
    localparam int GAPC = clamp_min1(GAP_CYCLES);
    localparam int TMO  = clamp_min1(ACK_TIMEOUT);
    localparam int SW   = stage_idx_width(NUM_STAGES);
    localparam int CW   = cnt_width(HOLD_CYCLES, GAP_CYCLES, ACK_TIMEOUT);

    localparam logic [CW-1:0] CNT_ZERO    = CW'(1'b0);
    localparam logic [CW-1:0] CNT_ONE     = CW'(1'b1);
    localparam logic [CW-1:0] HOLD_LAST   = CW'(HOLD - 1);
    localparam logic [CW-1:0] GAP_LAST    = CW'(GAPC - 1);
    localparam logic [CW-1:0] TMO_LAST    = CW'(TMO - 1);
    localparam logic [SW-1:0] IDX_ZERO    = SW'(1'b0);
    localparam logic [SW-1:0] IDX_ONE     = SW'(1'b1);
    localparam logic [SW-1:0] IDX_LAST    = SW'(NS - 1);
    localparam logic [NS-1:0] STAGE0_MASK = NS'(1'b1);
    localparam logic [NS-1:0] ALL_HELD    = NS'(1'b0);

    seq_state_t     state_r,       state_s;
    logic [CW-1:0]  cnt_r,         cnt_s;
    logic [SW-1:0]  idx_r,         idx_s;
    logic [NS-1:0]  rst_out_n_r,   rst_out_n_s;
    logic           seq_done_r,    seq_done_s;
    logic           fault_r,       fault_s;
    logic [SW-1:0]  fault_stage_r, fault_stage_s;
    logic [SW-1:0]  idx_inc_s;
    logic           ack_sel_s;

    // Only the ack of the stage currently being waited on matters.
    assign ack_sel_s = |(stage_ack & (STAGE0_MASK << idx_r));
    assign idx_inc_s = idx_r + IDX_ONE;

    // Next-state and next-output decode; registers are updated below.
    always_comb begin
        state_s       = state_r;
        cnt_s         = cnt_r;
        idx_s         = idx_r;
        rst_out_n_s   = rst_out_n_r;
        seq_done_s    = seq_done_r;
        fault_s       = fault_r;
        fault_stage_s = fault_stage_r;

        if (state_r == ASSERT) begin
            if (req_n) begin
                if (cnt_r == HOLD_LAST) begin
                    state_s     = WAIT_ACK;
                    rst_out_n_s = STAGE0_MASK;
                    idx_s       = IDX_ZERO;
                    cnt_s       = CNT_ZERO;
                end else begin
                    cnt_s = cnt_r + CNT_ONE;
                end
            end else begin
                cnt_s = CNT_ZERO;
            end
        end else if (!req_n) begin
            // A renewed reset request beats any ack or timeout; fault info is kept.
            state_s     = ASSERT;
            rst_out_n_s = ALL_HELD;
            seq_done_s  = 1'b0;
            cnt_s       = CNT_ZERO;
            idx_s       = IDX_ZERO;
        end else begin
            case (state_r)
                WAIT_ACK: begin
                    if (ack_sel_s) begin
                        if (idx_r == IDX_LAST) begin
                            state_s    = DONE;
                            seq_done_s = 1'b1;
                        end else begin
                            state_s = GAP;
                            cnt_s   = CNT_ZERO;
                        end
                    end else if (cnt_r == TMO_LAST) begin
                        state_s       = FAULT;
                        rst_out_n_s   = ALL_HELD;
                        fault_s       = 1'b1;
                        fault_stage_s = idx_r;
                    end else begin
                        cnt_s = cnt_r + CNT_ONE;
                    end
                end
                GAP: begin
                    if (cnt_r == GAP_LAST) begin
                        state_s     = WAIT_ACK;
                        idx_s       = idx_inc_s;
                        rst_out_n_s = rst_out_n_r | (STAGE0_MASK << idx_inc_s);
                        cnt_s       = CNT_ZERO;
                    end else begin
                        cnt_s = cnt_r + CNT_ONE;
                    end
                end
                DONE: begin
                    state_s = DONE;
                end
                FAULT: begin
                    state_s     = FAULT;
                    rst_out_n_s = ALL_HELD;
                end
                default: begin
                    state_s     = ASSERT;
                    rst_out_n_s = ALL_HELD;
                    seq_done_s  = 1'b0;
                    cnt_s       = CNT_ZERO;
                    idx_s       = IDX_ZERO;
                end
            endcase
        end
    end

    // State and output registers; rst overrides everything.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r       <= ASSERT;
            cnt_r         <= CNT_ZERO;
            idx_r         <= IDX_ZERO;
            rst_out_n_r   <= ALL_HELD;
            seq_done_r    <= 1'b0;
            fault_r       <= 1'b0;
            fault_stage_r <= IDX_ZERO;
        end else begin
            state_r       <= state_s;
            cnt_r         <= cnt_s;
            idx_r         <= idx_s;
            rst_out_n_r   <= rst_out_n_s;
            seq_done_r    <= seq_done_s;
            fault_r       <= fault_s;
            fault_stage_r <= fault_stage_s;
        end
    end

    assign rst_out_n   = rst_out_n_r;
    assign seq_done    = seq_done_r;
    assign fault       = fault_r;
    assign fault_stage = fault_stage_r;

endmodule

// File: tb/tb_reset_release_sequencer.sv
// Directed bench for reset_release_sequencer with hand-computed schedules
// (NUM_STAGES=4, HOLD=16, GAP=8, TIMEOUT=32).
module tb_reset_release_sequencer;

    logic       clk;
    logic       rst;
    logic       req_n;
    logic [3:0] stage_ack;
    logic [3:0] rst_out_n;
    logic       seq_done;
    logic       fault;
    logic [1:0] fault_stage;

    int checks_cnt = 0;
    int fail_cnt   = 0;

    reset_release_sequencer #(
        .NUM_STAGES  (4),
        .HOLD_CYCLES (16),
        .GAP_CYCLES  (8),
        .ACK_TIMEOUT (32)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .req_n       (req_n),
        .stage_ack   (stage_ack),
        .rst_out_n   (rst_out_n),
        .seq_done    (seq_done),
        .fault       (fault),
        .fault_stage (fault_stage)
    );

    // Free-running 10 ns clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks_cnt++;
        if (obs !== exp) begin
            fail_cnt++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance n rising edges and land 1 ns after the last one.
    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Stimulus and checks.
    initial begin
        rst       = 1'b1;
        req_n     = 1'b1;
        stage_ack = 4'b0000;
        step(2);
        chk_eq("reset_rst_out_n", 32'(rst_out_n), 32'h0);
        chk_eq("reset_seq_done", 32'(seq_done), 32'h0);
        chk_eq("reset_fault", 32'(fault), 32'h0);
        chk_eq("reset_fault_stage", 32'(fault_stage), 32'h0);

        // 1. Nominal: 16 high samples, then ack 3 cycles after each release.
        rst = 1'b0;
        step(15);
        chk_eq("nom_hold_not_early", 32'(rst_out_n), 32'h0);
        step(1);
        for (int s = 0; s < 4; s++) begin
            chk_eq($sformatf("nom_release_%0d", s), 32'(rst_out_n), 32'((1 << (s + 1)) - 1));
            step(2);
            stage_ack[s] = 1'b1;
            step(1);
            if (s == 3) begin
                chk_eq("nom_done", 32'(seq_done), 32'h1);
                chk_eq("nom_final_lines", 32'(rst_out_n), 32'hF);
            end else begin
                chk_eq($sformatf("nom_not_done_%0d", s), 32'(seq_done), 32'h0);
                step(7);
                chk_eq($sformatf("nom_gap_hold_%0d", s), 32'(rst_out_n), 32'((1 << (s + 1)) - 1));
                step(1);
            end
        end
        step(5);
        chk_eq("nom_done_hold", 32'(seq_done), 32'h1);
        chk_eq("nom_fault_clear", 32'(fault), 32'h0);

        // 2. Hold restart after a single low sample.
        req_n     = 1'b0;
        stage_ack = 4'b0000;
        step(1);
        chk_eq("reassert_lines", 32'(rst_out_n), 32'h0);
        chk_eq("reassert_done", 32'(seq_done), 32'h0);
        req_n = 1'b1;
        step(10);
        req_n = 1'b0;
        step(1);
        req_n = 1'b1;
        step(15);
        chk_eq("restart_not_early", 32'(rst_out_n), 32'h0);
        step(1);
        chk_eq("restart_release", 32'(rst_out_n), 32'h1);

        // 3. Timeout on stage 2; a high ack on stage 3 must be ignored.
        stage_ack[0] = 1'b1;
        step(9);
        chk_eq("tmo_stage1_rel", 32'(rst_out_n), 32'h3);
        stage_ack[1] = 1'b1;
        step(9);
        chk_eq("tmo_stage2_rel", 32'(rst_out_n), 32'h7);
        stage_ack[3] = 1'b1;
        step(31);
        chk_eq("tmo_pre_lines", 32'(rst_out_n), 32'h7);
        chk_eq("tmo_pre_fault", 32'(fault), 32'h0);
        step(1);
        chk_eq("tmo_lines", 32'(rst_out_n), 32'h0);
        chk_eq("tmo_fault", 32'(fault), 32'h1);
        chk_eq("tmo_fault_stage", 32'(fault_stage), 32'h2);
        stage_ack[2] = 1'b1;
        step(20);
        chk_eq("tmo_stays_held", 32'(rst_out_n), 32'h0);
        chk_eq("tmo_no_done", 32'(seq_done), 32'h0);

        // 4. Reassert during GAP after stage 1; fault stays sticky.
        req_n     = 1'b0;
        stage_ack = 4'b0000;
        step(1);
        chk_eq("fault_sticky", 32'(fault), 32'h1);
        chk_eq("fault_stage_kept", 32'(fault_stage), 32'h2);
        req_n = 1'b1;
        step(16);
        chk_eq("gap_seq_rel0", 32'(rst_out_n), 32'h1);
        stage_ack[0] = 1'b1;
        step(9);
        chk_eq("gap_seq_rel1", 32'(rst_out_n), 32'h3);
        stage_ack[1] = 1'b1;
        step(4);
        req_n = 1'b0;
        step(1);
        chk_eq("gap_reassert_lines", 32'(rst_out_n), 32'h0);
        chk_eq("gap_reassert_done", 32'(seq_done), 32'h0);
        req_n     = 1'b1;
        stage_ack = 4'b1111;
        step(16);
        chk_eq("reseq_rel0", 32'(rst_out_n), 32'h1);
        step(9);
        chk_eq("reseq_rel1", 32'(rst_out_n), 32'h3);
        step(9);
        chk_eq("reseq_rel2", 32'(rst_out_n), 32'h7);
        step(9);
        chk_eq("reseq_rel3", 32'(rst_out_n), 32'hF);
        chk_eq("reseq_not_done_yet", 32'(seq_done), 32'h0);
        step(1);
        chk_eq("reseq_done", 32'(seq_done), 32'h1);

        // 6. rst during WAIT_ACK for stage 2 clears everything, fault included.
        req_n     = 1'b0;
        stage_ack = 4'b0000;
        step(1);
        req_n = 1'b1;
        step(16);
        stage_ack[0] = 1'b1;
        step(9);
        stage_ack[1] = 1'b1;
        step(9);
        chk_eq("rst_mid_pre_lines", 32'(rst_out_n), 32'h7);
        step(3);
        rst = 1'b1;
        step(1);
        chk_eq("rst_mid_lines", 32'(rst_out_n), 32'h0);
        chk_eq("rst_mid_done", 32'(seq_done), 32'h0);
        chk_eq("rst_mid_fault", 32'(fault), 32'h0);
        chk_eq("rst_mid_fault_stage", 32'(fault_stage), 32'h0);

        // 5. Stage 1 ack first seen exactly on the timeout edge.
        rst       = 1'b0;
        stage_ack = 4'b0000;
        step(16);
        chk_eq("edge_rel0", 32'(rst_out_n), 32'h1);
        stage_ack[0] = 1'b1;
        step(9);
        chk_eq("edge_rel1", 32'(rst_out_n), 32'h3);
        step(31);
        chk_eq("edge_pre_lines", 32'(rst_out_n), 32'h3);
        stage_ack[1] = 1'b1;
        step(1);
        chk_eq("edge_ack_lines", 32'(rst_out_n), 32'h3);
        chk_eq("edge_ack_fault", 32'(fault), 32'h0);
        step(7);
        chk_eq("edge_gap_hold", 32'(rst_out_n), 32'h3);
        step(1);
        chk_eq("edge_rel2", 32'(rst_out_n), 32'h7);
        chk_eq("edge_final_fault", 32'(fault), 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", checks_cnt, fail_cnt);
        $finish;
    end

endmodule
